g18_flash_wb_bridge: RTL and testbench
======================================

// Module: g18_flash_wb_bridge
//
// PURPOSE
//   Wishbone B3 classic slave for the SoC boot/diag window. Turns each 32-bit read into two
//   16-bit asynchronous BPI flash reads on the G18 parallel bus: high half first, big-endian.
//   Sits between the orpsoc data bus and the G18 flash pins / kuba bus device.
//   Read-only: write cycles terminate with an error and never touch the flash.
//
// PARAMETERS
//   WAIT_CYCLES  8   sys_clk cycles each 16-bit word is held on flash_adr_o before sampling.
//                    Legal range >= 1; 8 gives 100 ns at 80 MHz.
//   ADDR_W       23  flash word-address width (16 MiB window, 16-bit words)
//
// PORTS
//   sys_clk_i     in   1       system clock (80 MHz)
//   sys_rst_i     in   1       asynchronous reset, active-high
//   wb_adr_i      in   32      byte address; bits [ADDR_W:2] select the 32-bit word; rest ignored
//   wb_dat_i      in   32      write data (unused; writes are rejected)
//   wb_sel_i      in   4       byte selects; ignored, reads always return all 32 bits
//   wb_we_i       in   1       write enable
//   wb_cyc_i      in   1       bus cycle
//   wb_stb_i      in   1       strobe
//   wb_dat_o      out  32      read data, valid while wb_ack_o=1
//   wb_ack_o      out  1       read completion, one-cycle pulse
//   wb_err_o      out  1       write rejection, one-cycle pulse
//   flash_adr_o   out  ADDR_W  flash word address
//   flash_dat_i   in   16      flash read data
//   flash_ce_n_o  out  1       chip enable, active-low
//   flash_oe_n_o  out  1       output enable, active-low
//   flash_we_n_o  out  1       write enable, active-low; tied 1
//
// BEHAVIOUR
//   - All outputs are registered.
//     Reset values: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, flash_adr_o=0,
//     flash_ce_n_o=1, flash_oe_n_o=1, flash_we_n_o=1; state=IDLE; cnt=0.
//   - FSM states: IDLE, RD_HI, RD_LO, ACK, ERR.
//   - IDLE, cyc&stb&!we at edge T0 -> RD_HI.
//       flash_adr_o={wb_adr_i[ADDR_W:2],1'b0}; ce_n=0; oe_n=0; cnt=WAIT_CYCLES-1.
//   - IDLE, cyc&stb&we -> ERR; wb_err_o=1 for exactly one cycle; flash pins unchanged.
//   - RD_HI: cnt decrements each cycle. At cnt==0:
//       wb_dat_o[31:16] <= flash_dat_i; flash_adr_o[0] <= 1; cnt reloads; -> RD_LO.
//   - RD_LO: at cnt==0: wb_dat_o[15:0] <= flash_dat_i; ce_n=1; oe_n=1; wb_ack_o=1; -> ACK.
//   - ACK and ERR -> IDLE unconditionally. cyc/stb are not sampled in these states, so there is
//     always at least one idle cycle between transactions.
//   - Latency: wb_ack_o is high in the cycle after edge T0+2*WAIT_CYCLES (16 cycles at default).
//     It is high for exactly 1 cycle.
//   - Abort: cyc_i=0 in RD_HI/RD_LO -> IDLE at next edge.
//       ce_n=1, oe_n=1, no ack, no err; wb_dat_o keeps its partially updated content.
//   - wb_dat_o holds the last read value between transactions.
//     Consumers qualify it with wb_ack_o only.
//   - Address wrap: bits above ADDR_W are ignored, so 0x0100_0000 aliases 0x0.
//   - Reset asserted mid-read: every output returns to its reset value immediately
//     (asynchronously); no ack follows.
//   - flash_we_n_o is constant 1; no program/erase support.
//
// STRUCTURE
//   - g18_pkg:
//       G18_ADDR_W=23, G18_DATA_W=16;
//       typedef enum logic [2:0] {IDLE,RD_HI,RD_LO,ACK,ERR} g18_state_t.
//   - Single module, no sub-modules. The wait counter is $clog2(WAIT_CYCLES+1) bits wide.
//
// TESTING
//   1. Read wb_adr_i=0x0, mem[0]=0x1234, mem[1]=0x5678, WAIT_CYCLES=8
//        -> flash_adr_o=0 then 1; wb_dat_o=0x12345678; ack exactly 16 cycles after accept, 1 cycle wide.
//   2. Read 0x0080_0000 (diag, word 0x400000)
//        -> flash_adr_o 0x400000 then 0x400001; data concatenated high word first.
//   3. Write cyc=stb=we=1
//        -> wb_err_o pulse 1 cycle after accept; ce_n/oe_n stay 1; no ack.
//   4. Drop cyc_i 3 cycles into RD_HI
//        -> IDLE next edge; ce_n=oe_n=1; no ack or err ever asserted for that cycle.
//   5. Assert sys_rst_i during RD_LO
//        -> outputs at reset values without a clock edge; next read completes normally.
//   6. Back-to-back reads with stb held
//        -> one idle cycle between acks; WAIT_CYCLES=1 gives ack 2 cycles after accept.

Source files
------------

// File: rtl/g18_pkg.sv
// Shared constants and state encoding for the G18 BPI flash Wishbone bridge.
package g18_pkg;

    localparam int G18_ADDR_W = 23;
    localparam int G18_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        ACK,
        ERR
    } g18_state_t;

endpackage

// File: rtl/g18_flash_wb_bridge.sv
// Wishbone B3 classic read-only slave: each 32-bit read becomes two timed 16-bit
// asynchronous BPI flash reads, high half first; writes terminate with an error.
module g18_flash_wb_bridge
    import g18_pkg::*;
#(
    parameter int WAIT_CYCLES = 8,
    parameter int ADDR_W      = G18_ADDR_W
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_W-1:0]     flash_adr_o,
    input  logic [G18_DATA_W-1:0] flash_dat_i,
    output logic                  flash_ce_n_o,
    output logic                  flash_oe_n_o,
    output logic                  flash_we_n_o
);

    localparam int               CNT_W      = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

    g18_state_t        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [31:0]       dat_d;
    logic              ack_d, err_d;
    logic [ADDR_W-1:0] adr_d;
    logic              ce_n_d, oe_n_d;

    // No program/erase path exists, so the write strobe is permanently inactive.
    assign flash_we_n_o = 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        dat_d   = wb_dat_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        adr_d   = flash_adr_o;
        ce_n_d  = flash_ce_n_o;
        oe_n_d  = flash_oe_n_o;

        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (wb_we_i) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RD_HI;
                        adr_d   = {wb_adr_i[ADDR_W:2], 1'b0};
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end

            RD_HI: begin
                // Master abort wins over a sample landing on the same edge.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else if (cnt == '0) begin
                    dat_d[31:16] = flash_dat_i;
                    adr_d[0]     = 1'b1;
                    cnt_d        = CNT_RELOAD;
                    state_d      = RD_LO;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            RD_LO: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else if (cnt == '0) begin
                    dat_d[15:0] = flash_dat_i;
                    ce_n_d      = 1'b1;
                    oe_n_d      = 1'b1;
                    ack_d       = 1'b1;
                    state_d     = ACK;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end

            // Termination states guarantee one idle cycle before the next request is taken.
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_dat_o     <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            flash_adr_o  <= '0;
            flash_ce_n_o <= 1'b1;
            flash_oe_n_o <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_d;
            cnt          <= cnt_d;
            wb_dat_o     <= dat_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            flash_adr_o  <= adr_d;
            flash_ce_n_o <= ce_n_d;
            flash_oe_n_o <= oe_n_d;
        end
    end

endmodule

// File: tb/tb_g18_flash_wb_bridge.sv
// Directed bench for g18_flash_wb_bridge: one instance at WAIT_CYCLES=8, one at WAIT_CYCLES=1.
`timescale 1ns/1ps
module tb_g18_flash_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdat_zero = 32'h0;
    logic [3:0]  sel_all   = 4'hF;

    always #5 clk = ~clk;

    // Instance A: default timing
    logic [31:0] a_adr, a_dat;
    logic        a_we, a_cyc, a_stb, a_ack, a_err, a_ce_n, a_oe_n, a_we_n;
    logic [22:0] a_fadr;
    logic [15:0] a_fdat;

    // Instance B: single wait cycle
    logic [31:0] b_adr, b_dat;
    logic        b_we, b_cyc, b_stb, b_ack, b_err, b_ce_n, b_oe_n, b_we_n;
    logic [22:0] b_fadr;
    logic [15:0] b_fdat;

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] flash_word(input logic [22:0] a);
        case (a)
            23'h000000: return 16'h1234;
            23'h000001: return 16'h5678;
            23'h400000: return 16'hCAFE;
            23'h400001: return 16'hBEEF;
            default:    return a[15:0] ^ 16'h5A00;
        endcase
    endfunction

    assign a_fdat = (!a_ce_n && !a_oe_n) ? flash_word(a_fadr) : 16'hFFFF;
    assign b_fdat = (!b_ce_n && !b_oe_n) ? flash_word(b_fadr) : 16'hFFFF;

    g18_flash_wb_bridge #(.WAIT_CYCLES(8), .ADDR_W(23)) u_a (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .wb_adr_i(a_adr), .wb_dat_i(wdat_zero), .wb_sel_i(sel_all),
        .wb_we_i(a_we), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb),
        .wb_dat_o(a_dat), .wb_ack_o(a_ack), .wb_err_o(a_err),
        .flash_adr_o(a_fadr), .flash_dat_i(a_fdat),
        .flash_ce_n_o(a_ce_n), .flash_oe_n_o(a_oe_n), .flash_we_n_o(a_we_n)
    );

    g18_flash_wb_bridge #(.WAIT_CYCLES(1), .ADDR_W(23)) u_b (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .wb_adr_i(b_adr), .wb_dat_i(wdat_zero), .wb_sel_i(sel_all),
        .wb_we_i(b_we), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb),
        .wb_dat_o(b_dat), .wb_ack_o(b_ack), .wb_err_o(b_err),
        .flash_adr_o(b_fadr), .flash_dat_i(b_fdat),
        .flash_ce_n_o(b_ce_n), .flash_oe_n_o(b_oe_n), .flash_we_n_o(b_we_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; issues one read on A and checks address phases, latency and data.
    task automatic a_read(input string tag, input logic [31:0] adr,
                          input logic [22:0] exp_word, input logic [31:0] exp_dat);
        int   n;
        logic got_ack;
        logic [22:0] hi_adr, lo_adr;
        logic [31:0] dat_at_ack;
        logic        ce_at_accept;
        a_adr = adr; a_we = 1'b0; a_cyc = 1'b1; a_stb = 1'b1;
        n = 0; got_ack = 1'b0; hi_adr = '0; lo_adr = '0; dat_at_ack = '0; ce_at_accept = 1'b1;
        while (!got_ack && n < 100) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 1) begin hi_adr = a_fadr; ce_at_accept = a_ce_n; end
            if (n == 9) lo_adr = a_fadr;
            if (a_ack) begin got_ack = 1'b1; dat_at_ack = a_dat; end
        end
        a_cyc = 1'b0; a_stb = 1'b0;
        check({tag, "_ce_n_active"}, {31'b0, ce_at_accept}, 32'd0);
        check({tag, "_adr_hi"}, {9'b0, hi_adr}, {9'b0, exp_word});
        check({tag, "_adr_lo"}, {9'b0, lo_adr}, {9'b0, exp_word | 23'd1});
        check({tag, "_ack_latency"}, n - 1, 32'd16);
        check({tag, "_data"}, dat_at_ack, exp_dat);
        @(posedge clk); @(negedge clk);
        check({tag, "_ack_width"}, {31'b0, a_ack}, 32'd0);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [7:0]  pattern;

        rst = 1'b1;
        a_adr = '0; a_we = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
        b_adr = '0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_dat",  a_dat, 32'h0);
        check("rst_ack_err", {30'b0, a_ack, a_err}, 32'h0);
        check("rst_fadr", {9'b0, a_fadr}, 32'h0);
        check("rst_pins", {29'b0, a_ce_n, a_oe_n, a_we_n}, 32'h7);
        rst = 1'b0;
        @(negedge clk);

        // Plain reads, diag window, and alias above the address window
        a_read("rd0",    32'h0000_0000, 23'h000000, 32'h1234_5678);
        a_read("rddiag", 32'h0080_0000, 23'h400000, 32'hCAFE_BEEF);
        a_read("rdwrap", 32'h0100_0004, 23'h000002, 32'h5A02_5A03);

        // Abort three cycles into RD_HI
        a_adr = 32'h0000_0008; a_we = 1'b0; a_cyc = 1'b1; a_stb = 1'b1;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        check("abort_mid_ce", {31'b0, a_ce_n}, 32'd0);
        a_cyc = 1'b0; a_stb = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_pins", {30'b0, a_ce_n, a_oe_n}, 32'h3);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); @(negedge clk); seen = seen | a_ack | a_err; end
        check("abort_no_ack_err", {31'b0, seen}, 32'd0);
        check("abort_dat_kept", a_dat, 32'h5A02_5A03);

        // Write is rejected with a single-cycle error
        a_adr = 32'h0000_0010; a_we = 1'b1; a_cyc = 1'b1; a_stb = 1'b1;
        @(posedge clk); @(negedge clk);
        check("wr_err", {31'b0, a_err}, 32'd1);
        check("wr_no_ack", {31'b0, a_ack}, 32'd0);
        check("wr_pins", {30'b0, a_ce_n, a_oe_n}, 32'h3);
        a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
        @(posedge clk); @(negedge clk);
        check("wr_err_width", {31'b0, a_err}, 32'd0);
        check("wr_pins_after", {30'b0, a_ce_n, a_oe_n}, 32'h3);

        // Asynchronous reset while in RD_LO
        a_adr = 32'h0000_0000; a_we = 1'b0; a_cyc = 1'b1; a_stb = 1'b1;
        repeat (12) begin @(posedge clk); @(negedge clk); end
        check("rlo_hi_loaded", {16'b0, a_dat[31:16]}, 32'h1234);
        #2 rst = 1'b1;
        #1;
        check("arst_dat", a_dat, 32'h0);
        check("arst_fadr", {9'b0, a_fadr}, 32'h0);
        check("arst_pins", {27'b0, a_ack, a_err, a_ce_n, a_oe_n, a_we_n}, 32'h7);
        a_cyc = 1'b0; a_stb = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen = seen | a_ack; end
        check("arst_no_ack", {31'b0, seen}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        a_read("rd_after_rst", 32'h0000_0000, 23'h000000, 32'h1234_5678);

        // Back-to-back reads on B with strobe held: acks after edges 3 and 7
        b_adr = 32'h0000_0000; b_we = 1'b0; b_cyc = 1'b1; b_stb = 1'b1;
        pattern = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            pattern[i] = b_ack;
            if (b_ack) check("b2b_data", b_dat, 32'h1234_5678);
        end
        b_cyc = 1'b0; b_stb = 1'b0;
        check("b2b_ack_pattern", {24'b0, pattern}, 32'h44);
        check("b2b_no_err", {31'b0, b_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
